// File: rtl/cmd_frame_rx_pkg.sv
// -----------------------------------------------------------------------------
// cmd_frame_rx_pkg
// Shared definitions for the command frame receiver:
//   state_t      - receiver FSM state encoding
//   mode_t       - operation mode encoding carried in frame byte B2[1:0]
//   HDR_BYTE_DEF - default frame header byte
// -----------------------------------------------------------------------------
package cmd_frame_rx_pkg;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_PAY1   = 3'd1,
    ST_PAY2   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'd0,
    MODE_HYBRID = 2'd1,
    MODE_MANUAL = 2'd2,
    MODE_SLEEP  = 2'd3
  } mode_t;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/cmd_frame_rx_err_window.sv
// -----------------------------------------------------------------------------
// cmd_err_window
// Counts completed frames and bad frames over a window of win_len frames.
// When the window closes, err_rate takes the bad count (including the frame
// closing the window), saturated to 15, and both counters restart.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   frame_done in   one-cycle strobe per completed frame (good or bad)
//   frame_bad  in   qualifies frame_done: the completed frame was bad
//   err_rate   out  bad frames in the last completed window
// -----------------------------------------------------------------------------
module cmd_err_window #(
  parameter int win_len = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_done,
  input  logic       frame_bad,
  output logic [3:0] err_rate
);

  localparam int CNT_W = $clog2(win_len + 1);
  localparam int SUM_W = (CNT_W + 1 > 5) ? CNT_W + 1 : 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(win_len - 1);

  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] bad_cnt;
  logic [SUM_W-1:0] bad_total;

  function automatic logic [3:0] sat_rate(input logic [SUM_W-1:0] v);
    if (v > SUM_W'(15)) return 4'hF;
    return v[3:0];
  endfunction

  // Bad count including the frame completing this cycle.
  assign bad_total = SUM_W'(bad_cnt) + SUM_W'(frame_bad);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      bad_cnt   <= '0;
      err_rate  <= '0;
    end else if (frame_done) begin
      if (frame_cnt == CNT_LAST) begin
        err_rate  <= sat_rate(bad_total);
        frame_cnt <= '0;
        bad_cnt   <= '0;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
        bad_cnt   <= bad_cnt + CNT_W'(frame_bad);
      end
    end
  end

endmodule

// File: rtl/cmd_frame_rx.sv
// -----------------------------------------------------------------------------
// cmd_frame_rx
// Receives 4-byte command frames {hdr, B1, B2, B3} from a byte stream and
// holds the decoded speed/direction/mode commands for the motor controller.
//   B1 = {speed[3:0], dir[3:0]}, B2 = {6'b0, mode[1:0]}, B3 = B1 ^ B2
// Good frames update the commands one cycle after the checksum byte; bad or
// stalled frames pulse frame_err. With no good frame for timeout_cycles the
// commands fall back to defaults in sleep mode and link_lost is raised.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   rx_data     in   received byte
//   rx_valid    in   rx_data valid
//   rx_ready    out  byte accepted this cycle when rx_valid is also high
//   speed_cmd_o out  held speed command
//   dir_cmd_o   out  held direction command
//   mode_o      out  operation mode (auto/hybrid/manual/sleep)
//   err_rate_o  out  bad frames in last completed error window
//   frame_ok    out  one-cycle pulse per good frame
//   frame_err   out  one-cycle pulse per bad frame
//   link_lost   out  no good frame within timeout_cycles
// -----------------------------------------------------------------------------
module cmd_frame_rx
  import cmd_frame_rx_pkg::*;
#(
  parameter int         cmd_l          = 4,
  parameter int         def_speed_cmd  = 5,
  parameter int         def_dir_cmd    = 8,
  parameter logic [7:0] hdr_byte       = HDR_BYTE_DEF,
  parameter int         win_len        = 16,
  parameter int         gap_max        = 32,
  parameter int         timeout_cycles = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [cmd_l-1:0] speed_cmd_o,
  output logic [cmd_l-1:0] dir_cmd_o,
  output logic [1:0]       mode_o,
  output logic [3:0]       err_rate_o,
  output logic             frame_ok,
  output logic             frame_err,
  output logic             link_lost
);

  localparam int GAP_W = $clog2(gap_max + 1);
  localparam int TMO_W = $clog2(timeout_cycles + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(gap_max - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(timeout_cycles);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(timeout_cycles - 1);
  localparam logic [cmd_l-1:0] DEF_SPEED = cmd_l'(def_speed_cmd);
  localparam logic [cmd_l-1:0] DEF_DIR   = cmd_l'(def_dir_cmd);

  state_t           state_q, state_d;
  logic             accept;
  logic             in_payload;
  logic             gap_hit;
  logic             commit_ev, good_ev, bad_ev, done_ev;
  logic             good_q;
  logic [7:0]       b1_q, b2_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;

  assign rx_ready   = (state_q != ST_COMMIT);
  assign accept     = rx_valid && rx_ready;
  assign in_payload = (state_q == ST_PAY1) || (state_q == ST_PAY2) ||
                      (state_q == ST_CSUM);

  // A frame stalls out on the gap_max-th consecutive idle cycle.
  assign gap_hit   = in_payload && !accept && (gap_cnt_q == GAP_LAST);
  assign commit_ev = (state_q == ST_COMMIT);
  assign good_ev   = commit_ev && good_q;
  assign bad_ev    = (commit_ev && !good_q) || gap_hit;
  assign done_ev   = commit_ev || gap_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_HUNT;
    else      state_q <= state_d;
  end

  // A header byte seen mid-frame is ordinary payload; there is no resync.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT:   if (accept && rx_data == hdr_byte) state_d = ST_PAY1;
      ST_PAY1:   if (accept) state_d = ST_PAY2; else if (gap_hit) state_d = ST_HUNT;
      ST_PAY2:   if (accept) state_d = ST_CSUM; else if (gap_hit) state_d = ST_HUNT;
      ST_CSUM:   if (accept) state_d = ST_COMMIT; else if (gap_hit) state_d = ST_HUNT;
      ST_COMMIT: state_d = ST_HUNT;
      default:   state_d = ST_HUNT;
    endcase
  end

  // Payload capture: data only, never needs a reset value.
  always_ff @(posedge clk) begin
    if (accept && state_q == ST_PAY1) b1_q <= rx_data;
    if (accept && state_q == ST_PAY2) b2_q <= rx_data;
  end

  // Checksum byte stage: judge the frame as B3 arrives, act on it in COMMIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt_q <= '0;
      good_q    <= 1'b0;
    end else begin
      if (!in_payload || accept || gap_hit) gap_cnt_q <= '0;
      else                                  gap_cnt_q <= gap_cnt_q + GAP_W'(1);
      if (accept && state_q == ST_CSUM)
        good_q <= (b2_q[7:2] == 6'd0) && (rx_data == (b1_q ^ b2_q));
    end
  end

  // Commit stage: command outputs, pulses and link supervision.
  // A good frame takes priority over a timeout landing on the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      speed_cmd_o <= DEF_SPEED;
      dir_cmd_o   <= DEF_DIR;
      mode_o      <= MODE_SLEEP;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      link_lost   <= 1'b1;
      tmo_cnt_q   <= '0;
    end else begin
      frame_ok  <= good_ev;
      frame_err <= bad_ev;
      if (good_ev) begin
        speed_cmd_o <= cmd_l'(b1_q[7:4]);
        dir_cmd_o   <= cmd_l'(b1_q[3:0]);
        mode_o      <= b2_q[1:0];
        link_lost   <= 1'b0;
        tmo_cnt_q   <= '0;
      end else begin
        if (tmo_cnt_q != TMO_MAX) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        if (tmo_cnt_q == TMO_LAST) begin
          speed_cmd_o <= DEF_SPEED;
          dir_cmd_o   <= DEF_DIR;
          mode_o      <= MODE_SLEEP;
          link_lost   <= 1'b1;
        end
      end
    end
  end

  cmd_err_window #(
    .win_len(win_len)
  ) u_err_window (
    .clk       (clk),
    .rst       (rst),
    .frame_done(done_ev),
    .frame_bad (bad_ev),
    .err_rate  (err_rate_o)
  );

endmodule

// File: tb/tb_cmd_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_cmd_frame_rx
// Directed frames for cmd_frame_rx. The stimulus process pushes the expected
// outcome of each frame into a queue; a monitor pops and compares whenever the
// DUT pulses frame_ok or frame_err.
// -----------------------------------------------------------------------------
module tb_cmd_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [3:0] speed_cmd_o;
  logic [3:0] dir_cmd_o;
  logic [1:0] mode_o;
  logic [3:0] err_rate_o;
  logic       frame_ok;
  logic       frame_err;
  logic       link_lost;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         ok;
    logic [3:0] spd;
    logic [3:0] dir;
    logic [1:0] mode;
    bit         lost;
  } exp_t;

  exp_t sbq[$];

  // Expected held state of the command outputs.
  logic [3:0] m_spd = 4'd5;
  logic [3:0] m_dir = 4'd8;
  logic [1:0] m_mode = 2'd3;
  bit         m_lost = 1'b1;

  cmd_frame_rx dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .speed_cmd_o(speed_cmd_o),
    .dir_cmd_o  (dir_cmd_o),
    .mode_o     (mode_o),
    .err_rate_o (err_rate_o),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .link_lost  (link_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    @(negedge clk);
    while (!rx_ready && g < 4) begin
      @(negedge clk);
      g++;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input bit good);
    exp_t e;
    if (good) begin
      m_spd  = b1[7:4];
      m_dir  = b1[3:0];
      m_mode = b2[1:0];
      m_lost = 1'b0;
    end
    e.ok = good; e.spd = m_spd; e.dir = m_dir; e.mode = m_mode; e.lost = m_lost;
    sbq.push_back(e);
    send_byte(8'hA5);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    @(negedge clk);
    chk("ready_in_commit", 32'(rx_ready), 0);
    @(negedge clk);
    chk("ready_after_commit", 32'(rx_ready), 1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_speed", 32'(speed_cmd_o), 5);
    chk("rst_dir", 32'(dir_cmd_o), 8);
    chk("rst_mode", 32'(mode_o), 3);
    chk("rst_err_rate", 32'(err_rate_o), 0);
    chk("rst_frame_ok", 32'(frame_ok), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_link_lost", 32'(link_lost), 1);
    chk("rst_rx_ready", 32'(rx_ready), 1);
    m_spd = 4'd5; m_dir = 4'd8; m_mode = 2'd3; m_lost = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: every frame_ok / frame_err pulse must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_ok || frame_err) begin
        if (sbq.size() == 0) begin
          chk("spurious_pulse", 32'({frame_ok, frame_err}), 0);
        end else begin
          e = sbq.pop_front();
          chk("pulse_kind", 32'({frame_ok, frame_err}), e.ok ? 2 : 1);
          chk("frame_speed", 32'(speed_cmd_o), 32'(e.spd));
          chk("frame_dir", 32'(dir_cmd_o), 32'(e.dir));
          chk("frame_mode", 32'(mode_o), 32'(e.mode));
          chk("frame_link_lost", 32'(link_lost), 32'(e.lost));
        end
      end
    end
  end

  initial begin
    int n;
    apply_reset();
    repeat (2) @(negedge clk);

    // Good frame, then bad checksum and reserved bits set.
    send_frame(8'h58, 8'h01, 8'h59, 1'b1);
    send_frame(8'h37, 8'h02, 8'h34, 1'b0);
    send_frame(8'h37, 8'h06, 8'h31, 1'b0);

    // Stall mid-frame: abort on the 32nd idle cycle.
    begin
      exp_t e;
      e.ok = 1'b0; e.spd = m_spd; e.dir = m_dir; e.mode = m_mode; e.lost = m_lost;
      sbq.push_back(e);
    end
    send_byte(8'hA5);
    send_byte(8'h58);
    n = 0;
    while (!frame_err && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("gap_abort_cycles", n, 33);
    // Back in HUNT: junk is dropped, next frame decodes.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'h37, 8'h02, 8'h35, 1'b1);

    // Reset mid-frame: no frame_err, outputs back to defaults.
    send_byte(8'hA5);
    send_byte(8'h58);
    apply_reset();
    repeat (3) @(negedge clk);

    // Error window: 16 frames with 3 bad, then 16 bad.
    for (int i = 0; i < 16; i++) begin
      if (i == 2 || i == 7 || i == 11) send_frame(8'h37, 8'h02, 8'h34, 1'b0);
      else                             send_frame(8'h58, 8'h01, 8'h59, 1'b1);
      if (i == 14) chk("err_rate_before_close", 32'(err_rate_o), 0);
    end
    chk("err_rate_3", 32'(err_rate_o), 3);
    for (int i = 0; i < 16; i++) begin
      send_frame(8'h37, 8'h02, 8'h34, 1'b0);
      if (i == 14) chk("err_rate_held", 32'(err_rate_o), 3);
    end
    chk("err_rate_sat", 32'(err_rate_o), 15);

    // Link timeout after a good frame, recovery on the next one.
    send_frame(8'h37, 8'h02, 8'h35, 1'b1);
    n = 0;
    while (!link_lost && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 1000);
    chk("timeout_speed", 32'(speed_cmd_o), 5);
    chk("timeout_dir", 32'(dir_cmd_o), 8);
    chk("timeout_mode", 32'(mode_o), 3);
    m_spd = 4'd5; m_dir = 4'd8; m_mode = 2'd3; m_lost = 1'b1;
    send_frame(8'hC4, 8'h00, 8'hC4, 1'b1);
    chk("recover_link", 32'(link_lost), 0);

    repeat (5) @(negedge clk);
    chk("queue_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
